// File: rtl/regfile_pkg.sv
// Shared constants for the register file slice.
// Core top level and the busy scoreboard take their default geometry from here
// so decode, writeback and the hazard unit all agree on register count and width.
package regfile_pkg;

  localparam int RF_WIDTH  = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_ADDR_W = 5;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for in-flight long-latency results.
// One busy bit per register plus a registered population count.
// Ports:
//   clock, ctrl_reset     rising-edge clock, synchronous active-high reset
//   set_en / set_idx      decode issued a long-latency op to set_idx
//   clr_en / clr_idx      long-latency result for clr_idx retired
//   lookup_a / lookup_b   indices whose registered busy bits are reported
//   busy_a / busy_b       registered busy state of the lookup indices
//   busy_count            number of set busy bits (registered)
// A set and a clear to the same register in one cycle leave it busy: a new op
// issued while the previous one retires still owns the register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic [ADDR_W-1:0] lookup_a,
  input  logic [ADDR_W-1:0] lookup_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic [ADDR_W:0]   busy_count
);

  localparam int CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [CNT_W-1:0] count_d;
  logic             set_ok;
  logic             clr_ok;
  logic             inc;
  logic             dec;

  // Register 0 is hard-wired when ZERO_REG is set: it never becomes busy.
  assign set_ok = set_en && !((ZERO_REG != 0) && (set_idx == '0));
  assign clr_ok = clr_en && !((ZERO_REG != 0) && (clr_idx == '0));

  // Count moves only on real state changes, so re-marking a busy register or
  // clearing an idle one leaves it alone.
  assign inc = set_ok && !busy_q[set_idx];
  assign dec = clr_ok && busy_q[clr_idx] && !(set_ok && (set_idx == clr_idx));

  always_comb begin
    busy_d = busy_q;
    if (clr_ok) busy_d[clr_idx] = 1'b0;
    // Applied after the clear so a same-cycle set wins.
    if (set_ok) busy_d[set_idx] = 1'b1;
  end

  assign count_d = busy_count + CNT_W'(inc) - CNT_W'(dec);

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      busy_q     <= '0;
      busy_count <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_count <= count_d;
    end
  end

  // Lookups see registered state only, never same-cycle marks or clears.
  assign busy_a = busy_q[lookup_a];
  assign busy_b = busy_q[lookup_b];

endmodule

// File: rtl/regfile_dualwb.sv
// Register file with two write ports, two async read ports and a busy scoreboard.
// WB0 is the pipeline writeback, WB1 the long-latency (mult/div) return which
// also retires the destination's busy bit.
// Ports:
//   clock, ctrl_reset                         clock, synchronous active-high reset
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg     WB0 write
//   ctrl_writeEnable2/ctrl_writeReg2/data_writeReg2  WB1 write + busy clear
//   ctrl_markBusy/ctrl_busyReg                decode marks a destination busy
//   ctrl_readRegA/B -> data_readRegA/B        combinational read ports
//   busy_readRegA/B                           registered busy bit of each read index
//   busy_count                                number of busy registers
// Read priority: hard-wired zero, then WB0 bypass, then WB1 bypass, then storage.
module regfile_dualwb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [WIDTH-1:0]  data_writeReg,
  input  logic              ctrl_writeEnable2,
  input  logic [ADDR_W-1:0] ctrl_writeReg2,
  input  logic [WIDTH-1:0]  data_writeReg2,
  input  logic              ctrl_markBusy,
  input  logic [ADDR_W-1:0] ctrl_busyReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [WIDTH-1:0]  data_readRegA,
  output logic [WIDTH-1:0]  data_readRegB,
  output logic              busy_readRegA,
  output logic              busy_readRegB,
  output logic [ADDR_W:0]   busy_count
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wb0_ok;
  logic              wb1_ok;
  logic              wb1_store;
  logic [ADDR_W-1:0] rd_idx  [2];
  logic [WIDTH-1:0]  rd_data [2];

  assign wb0_ok = ctrl_writeEnable  && !((ZERO_REG != 0) && (ctrl_writeReg  == '0));
  assign wb1_ok = ctrl_writeEnable2 && !((ZERO_REG != 0) && (ctrl_writeReg2 == '0));

  // WB0 owns the register when both ports target it.
  assign wb1_store = wb1_ok && !(wb0_ok && (ctrl_writeReg == ctrl_writeReg2));

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wb1_store) mem[ctrl_writeReg2] <= data_writeReg2;
      if (wb0_ok)    mem[ctrl_writeReg]  <= data_writeReg;
    end
  end

  assign rd_idx[0] = ctrl_readRegA;
  assign rd_idx[1] = ctrl_readRegB;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = mem[rd_idx[p]];
      if ((ZERO_REG != 0) && (rd_idx[p] == '0)) begin
        rd_data[p] = '0;
      end else if ((BYPASS != 0) && wb0_ok && (ctrl_writeReg == rd_idx[p])) begin
        rd_data[p] = data_writeReg;
      end else if ((BYPASS != 0) && wb1_ok && (ctrl_writeReg2 == rd_idx[p])) begin
        rd_data[p] = data_writeReg2;
      end
    end
  end

  assign data_readRegA = rd_data[0];
  assign data_readRegB = rd_data[1];

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .set_en     (ctrl_markBusy),
    .set_idx    (ctrl_busyReg),
    .clr_en     (ctrl_writeEnable2),
    .clr_idx    (ctrl_writeReg2),
    .lookup_a   (ctrl_readRegA),
    .lookup_b   (ctrl_readRegB),
    .busy_a     (busy_readRegA),
    .busy_b     (busy_readRegB),
    .busy_count (busy_count)
  );

endmodule

// File: tb/tb_regfile_dualwb.sv
// Directed bench for regfile_dualwb. Two instances share all inputs:
//   d1: BYPASS=1, ZERO_REG=1 (defaults)
//   d0: BYPASS=0, ZERO_REG=0
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit
// later, well away from the next edge.
module tb_regfile_dualwb;

  localparam int W = 32;
  localparam int A = 5;

  logic         clock;
  logic         ctrl_reset;
  logic         ctrl_writeEnable;
  logic [A-1:0] ctrl_writeReg;
  logic [W-1:0] data_writeReg;
  logic         ctrl_writeEnable2;
  logic [A-1:0] ctrl_writeReg2;
  logic [W-1:0] data_writeReg2;
  logic         ctrl_markBusy;
  logic [A-1:0] ctrl_busyReg;
  logic [A-1:0] ctrl_readRegA;
  logic [A-1:0] ctrl_readRegB;

  logic [W-1:0] a1, b1, a0, b0;
  logic         ba1, bb1, ba0, bb0;
  logic [A:0]   cnt1, cnt0;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  regfile_dualwb d1 (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_writeEnable2(ctrl_writeEnable2), .ctrl_writeReg2(ctrl_writeReg2), .data_writeReg2(data_writeReg2),
    .ctrl_markBusy(ctrl_markBusy), .ctrl_busyReg(ctrl_busyReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(a1), .data_readRegB(b1),
    .busy_readRegA(ba1), .busy_readRegB(bb1), .busy_count(cnt1)
  );

  regfile_dualwb #(.BYPASS(0), .ZERO_REG(0)) d0 (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_writeEnable2(ctrl_writeEnable2), .ctrl_writeReg2(ctrl_writeReg2), .data_writeReg2(data_writeReg2),
    .ctrl_markBusy(ctrl_markBusy), .ctrl_busyReg(ctrl_busyReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(a0), .data_readRegB(b0),
    .busy_readRegA(ba0), .busy_readRegB(bb0), .busy_count(cnt0)
  );

  // ---------------- clock / watchdog ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    ctrl_reset = 1'b0;
    ctrl_writeEnable = 1'b0;  ctrl_writeReg = '0;  data_writeReg = '0;
    ctrl_writeEnable2 = 1'b0; ctrl_writeReg2 = '0; data_writeReg2 = '0;
    ctrl_markBusy = 1'b0;     ctrl_busyReg = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    ctrl_readRegA = '0; ctrl_readRegB = '0;
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    for (int r = 0; r < 32; r++) begin
      ctrl_readRegA = A'(r);
      ctrl_readRegB = A'(31 - r);
      #1;
      checks++;
      if (a1 !== 32'h0 || b1 !== 32'h0 || a0 !== 32'h0 || b0 !== 32'h0) begin
        errors++;
        $display("FAIL reset_read r%0d: got %h %h %h %h required 0", r, a1, b1, a0, b0);
      end
      checks++;
      if ({ba1, bb1, ba0, bb0} !== 4'b0) begin
        errors++;
        $display("FAIL reset_busy r%0d: got %b required 0000", r, {ba1, bb1, ba0, bb0});
      end
    end
    checks++;
    if (cnt1 !== 6'd0 || cnt0 !== 6'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d/%0d required 0/0", cnt1, cnt0);
    end
  endtask

  task automatic test_bypass();
    idle();
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hDEADBEEF;
    ctrl_readRegA = 5'd5;
    #1;
    checks++;
    if (a1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bypass_same_cycle: got %h required DEADBEEF", a1);
    end
    checks++;
    if (a0 !== 32'h0) begin
      errors++; $display("FAIL nobypass_same_cycle: got %h required 00000000", a0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (a1 !== 32'hDEADBEEF || a0 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_next_cycle: got %h/%h required DEADBEEF", a1, a0);
    end
  endtask

  task automatic test_write_read();
    logic [W-1:0] e;
    idle();
    for (int r = 12; r < 18; r++) begin
      ctrl_writeEnable = 1'b1; ctrl_writeReg = A'(r);
      data_writeReg = 32'h0100_0000 * r + 32'h55;
      exp_q.push_back(data_writeReg);
      tick();
    end
    idle();
    for (int r = 12; r < 18; r++) begin
      ctrl_readRegB = A'(r);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (b1 !== e || b0 !== e) begin
        errors++; $display("FAIL readback_b r%0d: got %h/%h required %h", r, b1, b0, e);
      end
    end
  endtask

  task automatic test_dual_write();
    idle();
    ctrl_markBusy = 1'b1; ctrl_busyReg = 5'd7;
    tick();
    idle();
    ctrl_readRegA = 5'd7;
    #1;
    checks++;
    if (ba1 !== 1'b1 || ba0 !== 1'b1 || cnt1 !== 6'd1 || cnt0 !== 6'd1) begin
      errors++; $display("FAIL r7_marked: got %b%b cnt %0d/%0d required 11 cnt 1/1", ba1, ba0, cnt1, cnt0);
    end
    ctrl_writeEnable = 1'b1;  ctrl_writeReg = 5'd7;  data_writeReg = 32'h1111;
    ctrl_writeEnable2 = 1'b1; ctrl_writeReg2 = 5'd7; data_writeReg2 = 32'h2222;
    #1;
    checks++;
    if (a1 !== 32'h1111 || a0 !== 32'h0) begin
      errors++; $display("FAIL dual_same_cycle: got %h/%h required 00001111/00000000", a1, a0);
    end
    checks++;
    if (ba1 !== 1'b1) begin
      errors++; $display("FAIL busy_registered: got %b required 1", ba1);
    end
    tick();
    idle();
    #1;
    checks++;
    if (a1 !== 32'h1111 || a0 !== 32'h1111) begin
      errors++; $display("FAIL dual_wb0_wins: got %h/%h required 00001111", a1, a0);
    end
    checks++;
    if (ba1 !== 1'b0 || ba0 !== 1'b0 || cnt1 !== 6'd0 || cnt0 !== 6'd0) begin
      errors++; $display("FAIL dual_clear: got %b%b cnt %0d/%0d required 00 cnt 0/0", ba1, ba0, cnt1, cnt0);
    end
  endtask

  task automatic test_set_beats_clear();
    idle();
    ctrl_markBusy = 1'b1; ctrl_busyReg = 5'd3;
    tick();
    ctrl_readRegA = 5'd3;
    ctrl_writeEnable2 = 1'b1; ctrl_writeReg2 = 5'd3; data_writeReg2 = 32'h0000ABCD;
    #1;
    checks++;
    if (ba1 !== 1'b1 || cnt1 !== 6'd1 || cnt0 !== 6'd1) begin
      errors++; $display("FAIL r3_marked: got %b cnt %0d/%0d required 1 cnt 1/1", ba1, cnt1, cnt0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (ba1 !== 1'b1 || ba0 !== 1'b1 || cnt1 !== 6'd1 || cnt0 !== 6'd1) begin
      errors++; $display("FAIL set_beats_clear: got %b%b cnt %0d/%0d required 11 cnt 1/1", ba1, ba0, cnt1, cnt0);
    end
    checks++;
    if (a1 !== 32'h0000ABCD || a0 !== 32'h0000ABCD) begin
      errors++; $display("FAIL r3_data: got %h/%h required 0000ABCD", a1, a0);
    end
    ctrl_writeEnable2 = 1'b1; ctrl_writeReg2 = 5'd3; data_writeReg2 = 32'h0000ABCE;
    tick();
    idle();
    #1;
    checks++;
    if (ba1 !== 1'b0 || cnt1 !== 6'd0 || cnt0 !== 6'd0 || a1 !== 32'h0000ABCE) begin
      errors++; $display("FAIL r3_retire: got %b cnt %0d/%0d data %h required 0 cnt 0/0 data 0000ABCE", ba1, cnt1, cnt0, a1);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    ctrl_writeEnable = 1'b1;  ctrl_writeReg = 5'd10;  data_writeReg = 32'hA0A0A0A0;
    ctrl_writeEnable2 = 1'b1; ctrl_writeReg2 = 5'd11; data_writeReg2 = 32'hB1B1B1B1;
    ctrl_readRegA = 5'd10; ctrl_readRegB = 5'd11;
    #1;
    checks++;
    if (a1 !== 32'hA0A0A0A0 || b1 !== 32'hB1B1B1B1) begin
      errors++; $display("FAIL two_port_bypass: got %h/%h required A0A0A0A0/B1B1B1B1", a1, b1);
    end
    tick();
    ctrl_writeReg = 5'd11; data_writeReg = 32'h0C0C0C0C;
    ctrl_writeReg2 = 5'd10; data_writeReg2 = 32'h0D0D0D0D;
    #1;
    checks++;
    if (a0 !== 32'hA0A0A0A0 || b0 !== 32'hB1B1B1B1 || a1 !== 32'h0D0D0D0D || b1 !== 32'h0C0C0C0C) begin
      errors++; $display("FAIL b2b_mid: got %h %h %h %h required 0D0D0D0D 0C0C0C0C A0A0A0A0 B1B1B1B1", a1, b1, a0, b0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (a1 !== 32'h0D0D0D0D || b1 !== 32'h0C0C0C0C || a0 !== 32'h0D0D0D0D || b0 !== 32'h0C0C0C0C) begin
      errors++; $display("FAIL b2b_final: got %h %h %h %h required 0D0D0D0D 0C0C0C0C", a1, b1, a0, b0);
    end
    checks++;
    if (cnt1 !== 6'd0 || cnt0 !== 6'd0) begin
      errors++; $display("FAIL clear_idle_count: got %0d/%0d required 0/0", cnt1, cnt0);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    ctrl_writeEnable = 1'b1;  ctrl_writeReg = 5'd0;  data_writeReg = 32'hFFFFFFFF;
    ctrl_writeEnable2 = 1'b1; ctrl_writeReg2 = 5'd0; data_writeReg2 = 32'hFFFFFFFF;
    ctrl_markBusy = 1'b1; ctrl_busyReg = 5'd0;
    ctrl_readRegA = 5'd0;
    #1;
    checks++;
    if (a1 !== 32'h0) begin
      errors++; $display("FAIL zero_same_cycle: got %h required 00000000", a1);
    end
    tick();
    idle();
    #1;
    checks++;
    if (a1 !== 32'h0 || ba1 !== 1'b0 || cnt1 !== 6'd0) begin
      errors++; $display("FAIL zero_reg_on: got %h busy %b cnt %0d required 0 busy 0 cnt 0", a1, ba1, cnt1);
    end
    checks++;
    if (a0 !== 32'hFFFFFFFF || ba0 !== 1'b1 || cnt0 !== 6'd1) begin
      errors++; $display("FAIL zero_reg_off: got %h busy %b cnt %0d required FFFFFFFF busy 1 cnt 1", a0, ba0, cnt0);
    end
    // Retire r0 on the ordinary-r0 instance so both start the fill test empty.
    ctrl_writeEnable2 = 1'b1; ctrl_writeReg2 = 5'd0; data_writeReg2 = 32'h0;
    tick();
    idle();
    #1;
    checks++;
    if (ba0 !== 1'b0 || cnt0 !== 6'd0 || cnt1 !== 6'd0) begin
      errors++; $display("FAIL zero_retire: got busy %b cnt %0d/%0d required 0 cnt 0/0", ba0, cnt0, cnt1);
    end
  endtask

  task automatic test_fill_and_reset();
    idle();
    for (int r = 1; r < 32; r++) begin
      ctrl_markBusy = 1'b1; ctrl_busyReg = A'(r);
      tick();
    end
    idle();
    ctrl_readRegA = 5'd31; ctrl_readRegB = 5'd0;
    #1;
    checks++;
    if (cnt1 !== 6'd31 || cnt0 !== 6'd31) begin
      errors++; $display("FAIL fill_count: got %0d/%0d required 31/31", cnt1, cnt0);
    end
    checks++;
    if (ba1 !== 1'b1 || bb1 !== 1'b0 || ba0 !== 1'b1 || bb0 !== 1'b0) begin
      errors++; $display("FAIL fill_busy: got %b%b%b%b required 1010", ba1, bb1, ba0, bb0);
    end
    // Re-marking an already busy register must not move the count.
    ctrl_markBusy = 1'b1; ctrl_busyReg = 5'd5;
    tick();
    idle();
    #1;
    checks++;
    if (cnt1 !== 6'd31 || cnt0 !== 6'd31) begin
      errors++; $display("FAIL remark_count: got %0d/%0d required 31/31", cnt1, cnt0);
    end
    ctrl_reset = 1'b1;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'h5;
    ctrl_markBusy = 1'b1; ctrl_busyReg = 5'd0;
    tick();
    idle();
    ctrl_readRegA = 5'd9; ctrl_readRegB = 5'd5;
    #1;
    checks++;
    if (cnt1 !== 6'd0 || cnt0 !== 6'd0 || {ba1, bb1, ba0, bb0} !== 4'b0) begin
      errors++; $display("FAIL reset_busy_clear: got cnt %0d/%0d busy %b required 0/0 0000", cnt1, cnt0, {ba1, bb1, ba0, bb0});
    end
    checks++;
    if (a1 !== 32'h0 || a0 !== 32'h0 || b1 !== 32'h0 || b0 !== 32'h0) begin
      errors++; $display("FAIL reset_drops_write: got %h %h %h %h required 0", a1, a0, b1, b0);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle();
    ctrl_readRegA = '0;
    ctrl_readRegB = '0;
    test_reset();
    test_bypass();
    test_write_read();
    test_dual_write();
    test_set_beats_clear();
    test_back_to_back();
    test_zero_reg();
    test_fill_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
